product_bcd_display: RTL

Downstream display stage for the 4-bit multiplier on the DE1-SoC. It captures the 8-bit product when the multiplier's `done` rises and converts it to three BCD digits with a sequential double-dabble, one shift per cycle. It then drives three seven-segment displays (HEX2..HEX0) with registered, active-low segment codes. The last result stays on the displays until a new product arrives or reset is asserted.

---
 rtl/display_pkg.sv | 35 +++
 rtl/seven_seg_decoder.sv | 18 +
 rtl/product_bcd_display.sv | 138 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and segment tables for the product display stage.
// Digit codes are stored active-low to match the DE1-SoC HEX wiring.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Active-low code for a digit, or blank; inverted for active-high boards.
  function automatic logic [6:0] seg_code(
    input logic [3:0] d,
    input logic       blank,
    input bit         active_low
  );
    logic [6:0] c;
    if (blank || d > 4'd9) c = SEG_BLANK;
    else                   c = SEG_DIGIT[d];
    return active_low ? c : ~c;
  endfunction

  // Double-dabble correction for one BCD nibble ahead of a shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to seven-segment decoder.
// Output bit order is {g,f,e,d,c,b,a}.
module seven_seg_decoder
  import display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup with blanking and polarity handled in the helper.
  always_comb begin
    seg = seg_code(digit, blank, ACTIVE_LOW);
  end

endmodule

// File: rtl/product_bcd_display.sv
// Captures the multiplier product on done's rising edge, converts it
// to BCD by serial double-dabble and drives three HEX displays.
module product_bcd_display
  import display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Y,
  input  logic       done,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic       busy,
  output logic       valid
);

  localparam logic [6:0] RST_LEAD =
    seg_code(4'd0, BLANK_LEADING, ACTIVE_LOW);
  localparam logic [6:0] RST_UNIT =
    seg_code(4'd0, 1'b0, ACTIVE_LOW);

  state_t      state;
  state_t      state_nx;
  logic        done_q;
  logic        cap;
  logic [19:0] sh;
  logic [19:0] dab;
  logic [2:0]  cnt;
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic        blank2;
  logic        blank1;
  logic [6:0]  seg0;
  logic [6:0]  seg1;
  logic [6:0]  seg2;

  assign cap   = done & ~done_q;
  assign busy  = (state != IDLE);
  assign hund  = sh[19:16];
  assign tens  = sh[15:12];
  assign units = sh[11:8];

  // done_q resets high so a level held across reset is not an event.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b1;
    else     done_q <= done;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; eight shifts then one update cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cap) state_nx = CONVERT;
      CONVERT: if (cnt == 3'd7) state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Nibble corrections applied before each shift.
  always_comb begin
    dab = {add3(sh[19:16]), add3(sh[15:12]),
           add3(sh[11:8]), sh[7:0]};
  end

  // Shift register and shift counter; Y is sampled only at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cap) begin
            sh  <= {12'b0, Y};
            cnt <= '0;
          end
        end
        CONVERT: begin
          sh  <= {dab[18:0], 1'b0};
          cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    blank2 = BLANK_LEADING && (hund == 4'd0);
    blank1 = BLANK_LEADING && (hund == 4'd0) && (tens == 4'd0);
  end

  seven_seg_decoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec0 (
    .digit(units),
    .blank(1'b0),
    .seg  (seg0)
  );

  seven_seg_decoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec1 (
    .digit(tens),
    .blank(blank1),
    .seg  (seg1)
  );

  seven_seg_decoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec2 (
    .digit(hund),
    .blank(blank2),
    .seg  (seg2)
  );

  // Display registers hold the last result until the next update.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex0  <= RST_UNIT;
      hex1  <= RST_LEAD;
      hex2  <= RST_LEAD;
      valid <= 1'b0;
    end else begin
      valid <= (state == UPDATE);
      if (state == UPDATE) begin
        hex0 <= seg0;
        hex1 <= seg1;
        hex2 <= seg2;
      end
    end
  end

endmodule
